// File: rtl/laser_pkg.sv
// Shared constants, FSM encoding and result record for the LASER arbiter.
package laser_pkg;

    localparam int unsigned N_PTS_DEF = 40;
    localparam int unsigned COORD_W   = 4;
    localparam int unsigned PT_W      = 2 * COORD_W;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        STREAM    = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } laser_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] c1x;
        logic [COORD_W-1:0] c1y;
        logic [COORD_W-1:0] c2x;
        logic [COORD_W-1:0] c2y;
        logic               err;
    } laser_res_t;

    // Buffer word layout: Y in the upper half, X in the lower half.
    function automatic logic [PT_W-1:0] pack_pt(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Frame point buffer: one write port, one registered read port holding its value when idle.
module laser_pt_buf
    import laser_pkg::*;
#(
    parameter int unsigned DEPTH = N_PTS_DEF,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PT_W-1:0] wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [PT_W-1:0] rd_data
);

    logic [PT_W-1:0] mem [DEPTH];

    // Point storage; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data; this register drives the engine point bus directly.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/laser_arb.sv
// Round-robin front end sharing one LASER engine between two point-set requesters.
module laser_arb
    import laser_pkg::*;
#(
    parameter int unsigned N_PTS   = N_PTS_DEF,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   IN_VALID,
    output logic [1:0]   IN_READY,
    input  logic [7:0]   IN_X,
    input  logic [7:0]   IN_Y,
    output logic         ENG_RST,
    output logic [3:0]   ENG_X,
    output logic [3:0]   ENG_Y,
    input  logic         ENG_DONE,
    input  logic [3:0]   ENG_C1X,
    input  logic [3:0]   ENG_C1Y,
    input  logic [3:0]   ENG_C2X,
    input  logic [3:0]   ENG_C2Y,
    output logic         RES_VALID,
    input  logic         RES_READY,
    output logic         RES_ID,
    output logic [3:0]   RES_C1X,
    output logic [3:0]   RES_C1Y,
    output logic [3:0]   RES_C2X,
    output logic [3:0]   RES_C2Y,
    output logic         RES_ERR,
    output logic         BUSY
);

    localparam int unsigned CNT_W = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam int unsigned WD_W  = 16;
    localparam logic [CNT_W-1:0] LAST_PT = CNT_W'(N_PTS - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

    laser_state_t     state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    laser_res_t       res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic             res_id_q, res_id_d;
    logic             eng_rst_q, eng_rst_d;
    logic             busy_q, busy_d;

    logic             beat;
    logic [PT_W-1:0]  wr_data;
    logic             rd_en;
    logic [CNT_W-1:0] rd_addr;
    logic [PT_W-1:0]  rd_data;

    // Only the granted requester is offered a ready, and only while loading.
    assign IN_READY = (state_q == LOAD) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign beat     = (state_q == LOAD) && (gnt_q ? IN_VALID[1] : IN_VALID[0]);
    assign wr_data  = gnt_q ? pack_pt(IN_X[7:4], IN_Y[7:4])
                            : pack_pt(IN_X[3:0], IN_Y[3:0]);

    laser_pt_buf #(
        .DEPTH (N_PTS),
        .AW    (CNT_W)
    ) u_buf (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (beat),
        .wr_addr (cnt_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            wd_q        <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            eng_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            eng_rst_q   <= eng_rst_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, buffer read control and next register values.
    // The read register is one cycle ahead of STREAM so point k is on the bus in stream cycle k.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        eng_rst_d   = 1'b1;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|IN_VALID) begin
                    gnt_d   = IN_VALID[rr_q] ? rr_q : ~rr_q;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (cnt_q == LAST_PT) begin
                        cnt_d   = '0;
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        state_d = STREAM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (cnt_q == LAST_PT) begin
                    cnt_d   = '0;
                    wd_d    = '0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    rd_en   = 1'b1;
                    rd_addr = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ENG_DONE) begin
                    res_d    = '{c1x: ENG_C1X, c1y: ENG_C1Y, c2x: ENG_C2X, c2y: ENG_C2Y, err: 1'b0};
                    res_id_d = gnt_q;
                    state_d  = RESP;
                end else if (wd_q == WD_LAST) begin
                    res_d     = '0;
                    res_d.err = 1'b1;
                    res_id_d  = gnt_q;
                    state_d   = RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RESP: begin
                if (RES_READY) begin
                    rr_d    = ~gnt_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        eng_rst_d   = !((state_d == STREAM) || (state_d == WAIT_DONE));
        res_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    assign ENG_RST   = eng_rst_q;
    assign ENG_X     = rd_data[COORD_W-1:0];
    assign ENG_Y     = rd_data[PT_W-1:COORD_W];
    assign RES_VALID = res_valid_q;
    assign RES_ID    = res_id_q;
    assign RES_C1X   = res_q.c1x;
    assign RES_C1Y   = res_q.c1y;
    assign RES_C2X   = res_q.c2x;
    assign RES_C2Y   = res_q.c2y;
    assign RES_ERR   = res_q.err;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_laser_arb.sv
// Directed bench for laser_arb: frame table plus hand-written watchdog, reset and fairness sequences.
module tb_laser_arb;

    localparam int N_PTS = 40;

    typedef struct {
        bit         req;
        int         pat;
        int         gap_at;
        int         gap_len;
        int         delay;
        logic [3:0] c1x;
        logic [3:0] c1y;
        logic [3:0] c2x;
        logic [3:0] c2y;
        int         hold;
        bit         exp_id;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_x;
    logic [7:0] in_y;
    logic       eng_rst;
    logic [3:0] eng_x, eng_y;
    logic       eng_done = 1'b0;
    logic [3:0] eng_c1x, eng_c1y, eng_c2x, eng_c2y;
    logic       res_valid, res_ready, res_id;
    logic [3:0] res_c1x, res_c1y, res_c2x, res_c2y;
    logic       res_err, busy;

    logic [1:0] b_in_valid;
    logic [1:0] b_in_ready;
    logic       b_eng_rst;
    logic [3:0] b_eng_x, b_eng_y;
    logic       b_eng_done;
    logic       b_res_valid, b_res_ready, b_res_id;
    logic [3:0] b_res_c1x, b_res_c1y, b_res_c2x, b_res_c2y;
    logic       b_res_err, b_busy;

    int checks   = 0;
    int failures = 0;
    int done_delay = -1;
    int ecnt = 0;

    frame_vec_t vecs [4];

    always #5 clk = ~clk;

    laser_arb #(.N_PTS(40)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_X(in_x), .IN_Y(in_y),
        .ENG_RST(eng_rst), .ENG_X(eng_x), .ENG_Y(eng_y), .ENG_DONE(eng_done),
        .ENG_C1X(eng_c1x), .ENG_C1Y(eng_c1y), .ENG_C2X(eng_c2x), .ENG_C2Y(eng_c2y),
        .RES_VALID(res_valid), .RES_READY(res_ready), .RES_ID(res_id),
        .RES_C1X(res_c1x), .RES_C1Y(res_c1y), .RES_C2X(res_c2x), .RES_C2Y(res_c2y),
        .RES_ERR(res_err), .BUSY(busy)
    );

    laser_arb #(.N_PTS(40), .TIMEOUT(100)) dut_wd (
        .CLK(clk), .RST(rst),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_X(in_x), .IN_Y(in_y),
        .ENG_RST(b_eng_rst), .ENG_X(b_eng_x), .ENG_Y(b_eng_y), .ENG_DONE(b_eng_done),
        .ENG_C1X(eng_c1x), .ENG_C1Y(eng_c1y), .ENG_C2X(eng_c2x), .ENG_C2Y(eng_c2y),
        .RES_VALID(b_res_valid), .RES_READY(b_res_ready), .RES_ID(b_res_id),
        .RES_C1X(b_res_c1x), .RES_C1Y(b_res_c1y), .RES_C2X(b_res_c2x), .RES_C2Y(b_res_c2y),
        .RES_ERR(b_res_err), .BUSY(b_busy)
    );

    // Engine model: DONE pulses done_delay cycles after the 40-cycle stream (never when negative).
    always @(negedge clk) begin
        if (eng_rst) begin
            ecnt     <= 0;
            eng_done <= 1'b0;
        end else begin
            ecnt     <= ecnt + 1;
            eng_done <= (done_delay >= 0) && (ecnt + 1 == N_PTS + done_delay);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "global timeout");
    end

    function automatic logic [3:0] pt_x(input int pat, input int i);
        case (pat)
            0:       return 4'(i % 16);
            1:       return 4'((5 * i + 1) % 16);
            default: return 4'(15 - (i % 16));
        endcase
    endfunction

    function automatic logic [3:0] pt_y(input int pat, input int i);
        case (pat)
            0:       return 4'((3 * i) % 16);
            1:       return 4'((7 * i + 2) % 16);
            default: return 4'((i / 3) % 16);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one frame on requester req, optionally stalling gap_len cycles at point gap_at.
    task automatic load_frame(input bit req, input int pat, input int gap_at, input int gap_len);
        int idx = 0;
        int gap = 0;
        int guard = 0;
        int both = 0;
        int bad_rst = 0;
        bit acc;
        logic [3:0] px, py;
        while (idx < N_PTS && guard < 500) begin
            if (idx == gap_at && gap < gap_len && in_ready != 2'b00) begin
                in_valid = 2'b00;
                in_x = 8'hFF;
                in_y = 8'hFF;
                gap++;
            end else begin
                px = pt_x(pat, idx);
                py = pt_y(pat, idx);
                in_valid = req ? 2'b10 : 2'b01;
                in_x = req ? {px, ~px} : {~px, px};
                in_y = req ? {py, ~py} : {~py, py};
            end
            if (in_ready == 2'b11) both++;
            if (!eng_rst) bad_rst++;
            acc = req ? (in_valid[1] && in_ready[1]) : (in_valid[0] && in_ready[0]);
            @(negedge clk);
            guard++;
            if (acc) idx++;
        end
        in_valid = 2'b00;
        check("load_beats", 32'(idx), 32'(N_PTS));
        check("load_ready_both", 32'(both), 32'd0);
        check("load_eng_rst_high", 32'(bad_rst), 32'd0);
    endtask

    // Expect point k on the engine bus in the k-th cycle with ENG_RST low, then a hold of the last point.
    task automatic stream_check(input int pat);
        for (int k = 0; k < N_PTS; k++) begin
            check($sformatf("stream_pt%0d", k), 32'({eng_rst, eng_x, eng_y}),
                  32'({1'b0, pt_x(pat, k), pt_y(pat, k)}));
            @(negedge clk);
        end
        check("stream_hold_last", 32'({eng_rst, eng_x, eng_y, busy}),
              32'({1'b0, pt_x(pat, N_PTS - 1), pt_y(pat, N_PTS - 1), 1'b1}));
    endtask

    task automatic run_frame(input frame_vec_t v);
        int guard = 0;
        eng_c1x = v.c1x; eng_c1y = v.c1y; eng_c2x = v.c2x; eng_c2y = v.c2y;
        done_delay = v.delay;
        load_frame(v.req, v.pat, v.gap_at, v.gap_len);
        stream_check(v.pat);
        while (!res_valid && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("res_valid", 32'(res_valid), 32'd1);
        check("res_payload", 32'({res_id, res_c1x, res_c1y, res_c2x, res_c2y, res_err}),
              32'({v.exp_id, v.c1x, v.c1y, v.c2x, v.c2y, 1'b0}));
        check("resp_eng_rst", 32'({eng_rst, in_ready}), 32'({1'b1, 2'b00}));
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 2'b11;
            in_x = 8'h77;
            @(negedge clk);
            check($sformatf("resp_hold%0d", h),
                  32'({res_valid, res_id, res_c1x, res_c1y, res_c2x, res_c2y, res_err, in_ready}),
                  32'({1'b1, v.exp_id, v.c1x, v.c1y, v.c2x, v.c2y, 1'b0, 2'b00}));
        end
        res_ready = 1'b1;
        in_valid = 2'b00;
        @(negedge clk);
        res_ready = 1'b0;
        check("resp_release", 32'({res_valid, busy}), 32'd0);
    endtask

    // Watchdog instance: count cycles with ENG_RST low until the result shows up.
    task automatic b_run(input bit done_at_limit, input bit exp_err);
        int low = 0;
        int beats = 0;
        int guard = 0;
        b_res_ready = 1'b0;
        in_x = 8'h5A;
        in_y = 8'hC3;
        while (!b_res_valid && guard < 600) begin
            b_in_valid = (beats < N_PTS) ? 2'b01 : 2'b00;
            if (b_in_ready[0] && b_in_valid[0]) beats++;
            if (!b_eng_rst) low++;
            b_eng_done = done_at_limit ? (low == 140) : (low <= 40);
            @(negedge clk);
            guard++;
        end
        b_in_valid = 2'b00;
        b_eng_done = 1'b0;
        check("wd_beats", 32'(beats), 32'(N_PTS));
        check("wd_low_cycles", 32'(low), 32'd140);
        check("wd_res_valid", 32'({b_res_valid, b_eng_rst, b_res_id}), 32'({1'b1, 1'b1, 1'b0}));
        if (exp_err)
            check("wd_err_payload", 32'({b_res_c1x, b_res_c1y, b_res_c2x, b_res_c2y, b_res_err}),
                  32'({16'h0000, 1'b1}));
        else
            check("wd_done_at_limit", 32'({b_res_c1x, b_res_c1y, b_res_c2x, b_res_c2y, b_res_err}),
                  32'({4'd5, 4'd6, 4'd7, 4'd8, 1'b0}));
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready = 1'b0;
        check("wd_release", 32'({b_res_valid, b_busy}), 32'd0);
    endtask

    initial begin
        int n;
        int g;
        int both;
        bit grants [4];
        logic [1:0] prev;
        logic [1:0] r;

        vecs[0] = '{req: 1'b0, pat: 0, gap_at: -1, gap_len: 0, delay: 200,
                    c1x: 4'd3, c1y: 4'd4, c2x: 4'd11, c2y: 4'd9, hold: 0, exp_id: 1'b0};
        vecs[1] = '{req: 1'b1, pat: 1, gap_at: 17, gap_len: 5, delay: 10,
                    c1x: 4'd1, c1y: 4'd2, c2x: 4'd13, c2y: 4'd14, hold: 10, exp_id: 1'b1};
        vecs[2] = '{req: 1'b1, pat: 2, gap_at: -1, gap_len: 0, delay: 1,
                    c1x: 4'd6, c1y: 4'd7, c2x: 4'd0, c2y: 4'd15, hold: 0, exp_id: 1'b1};
        vecs[3] = '{req: 1'b0, pat: 2, gap_at: -1, gap_len: 0, delay: 7,
                    c1x: 4'd15, c1y: 4'd0, c2x: 4'd8, c2y: 4'd1, hold: 3, exp_id: 1'b0};

        rst = 1'b1;
        in_valid = 2'b00; in_x = 8'h00; in_y = 8'h00;
        res_ready = 1'b0;
        b_in_valid = 2'b00; b_eng_done = 1'b0; b_res_ready = 1'b0;
        eng_c1x = 4'd9; eng_c1y = 4'd9; eng_c2x = 4'd9; eng_c2y = 4'd9;
        repeat (3) @(negedge clk);
        check("reset_main", 32'({eng_rst, eng_x, eng_y, in_ready, res_valid, res_id,
                                 res_c1x, res_c1y, res_c2x, res_c2y, res_err, busy}),
              32'({1'b1, 30'd0}));
        check("reset_wd", 32'({b_eng_rst, b_eng_x, b_eng_y, b_in_ready, b_res_valid, b_res_id,
                               b_res_c1x, b_res_c1y, b_res_c2x, b_res_c2y, b_res_err, b_busy}),
              32'({1'b1, 30'd0}));
        rst = 1'b0;
        @(negedge clk);

        // Watchdog: DONE outside WAIT_DONE ignored, then abort; then DONE exactly at the limit.
        b_run(1'b0, 1'b1);
        eng_c1x = 4'd5; eng_c1y = 4'd6; eng_c2x = 4'd7; eng_c2y = 4'd8;
        b_run(1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i]);
        end

        // Reset during STREAM at point 20, then a full reload with a different pattern.
        done_delay = 5;
        load_frame(1'b0, 0, -1, 0);
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1 check("mid_reset", 32'({eng_rst, busy, res_valid, in_ready}), 32'({1'b1, 1'b0, 1'b0, 2'b00}));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(vecs[3]);

        // Fairness from reset with both requesters continuously valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        done_delay = 3;
        res_ready = 1'b1;
        in_valid = 2'b11;
        in_x = 8'h21;
        in_y = 8'h43;
        n = 0; g = 0; both = 0; prev = 2'b00;
        while (g < 3000) begin
            r = in_ready;
            if (r == 2'b11) both++;
            if (prev == 2'b00 && r != 2'b00 && n < 4) begin
                grants[n] = r[1];
                n++;
            end
            if (n == 4 && prev != 2'b00 && r == 2'b00) break;
            prev = r;
            @(negedge clk);
            g++;
        end
        in_valid = 2'b00;
        check("fair_grant_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        end
        check("fair_ready_both", 32'(both), 32'd0);
        g = 0;
        while (busy && g < 500) begin
            @(negedge clk);
            g++;
        end
        res_ready = 1'b0;
        check("fair_drain_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
